// File: rtl/wavetable_pkg.sv
// Shared definitions for the wavetable oscillator: ROM/sample widths, the
// frame FSM state encoding, the per-voice config payload and the sample
// format conversion.
package wavetable_pkg;

    localparam int unsigned SAMPLE_ADDR_W = 6;
    localparam int unsigned PROG_ADDR_W   = 7;
    localparam int unsigned SAMPLE_W      = 8;
    localparam int unsigned GAIN_W        = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ACC   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Per-voice configuration payload; the increment is kept separate since
    // its width follows the PHASE_W parameter.
    typedef struct packed {
        logic [PROG_ADDR_W-1:0] prog;
        logic [GAIN_W-1:0]      gain;
        logic                   gate;
    } voice_cfg_t;

    // Offset-binary ROM sample to two's complement.
    function automatic logic signed [SAMPLE_W-1:0] to_signed(input logic [SAMPLE_W-1:0] raw);
        return $signed(raw ^ SAMPLE_W'(8'h80));
    endfunction

endpackage

// File: rtl/wavetable_voice_regs.sv
// Per-voice storage: increment, program, gain, gate and phase accumulator.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   cfg_we_i/voice/inc/cfg configuration write
//   adv_i, adv_voice_i     advance the phase of one voice by its increment
//   rd_voice_i             voice selected for the combinational read port
//   rd_*_c                 program, gain, gate and sample address of rd_voice_i
module wavetable_voice_regs import wavetable_pkg::*; #(
    parameter  int unsigned NUM_VOICES = 8,
    parameter  int unsigned PHASE_W    = 16,
    localparam int unsigned VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we_i,
    input  logic [VOICE_W-1:0]       cfg_voice_i,
    input  logic [PHASE_W-1:0]       cfg_inc_i,
    input  voice_cfg_t               cfg_i,
    input  logic                     adv_i,
    input  logic [VOICE_W-1:0]       adv_voice_i,
    input  logic [VOICE_W-1:0]       rd_voice_i,
    output logic [PROG_ADDR_W-1:0]   rd_prog_c,
    output logic [GAIN_W-1:0]        rd_gain_c,
    output logic                     rd_gate_c,
    output logic [SAMPLE_ADDR_W-1:0] rd_sample_c
);

    logic [PHASE_W-1:0] inc_q   [NUM_VOICES];
    logic [PHASE_W-1:0] phase_q [NUM_VOICES];
    logic [PHASE_W-1:0] phase_d [NUM_VOICES];
    voice_cfg_t         cfg_q   [NUM_VOICES];

    // Phase next-state: advance with the current increment, then let a gate
    // write override it (rising gate or gate-off both park the phase at 0).
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            phase_d[v] = phase_q[v];
            if (adv_i && (adv_voice_i == VOICE_W'(v)) && cfg_q[v].gate) begin
                phase_d[v] = phase_q[v] + inc_q[v];
            end
            if (cfg_we_i && (cfg_voice_i == VOICE_W'(v)) && (!cfg_i.gate || !cfg_q[v].gate)) begin
                phase_d[v] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                inc_q[v]   <= '0;
                phase_q[v] <= '0;
                cfg_q[v]   <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= phase_d[v];
            end
            if (cfg_we_i) begin
                inc_q[cfg_voice_i] <= cfg_inc_i;
                cfg_q[cfg_voice_i] <= cfg_i;
            end
        end
    end

    assign rd_prog_c   = cfg_q[rd_voice_i].prog;
    assign rd_gain_c   = cfg_q[rd_voice_i].gain;
    assign rd_gate_c   = cfg_q[rd_voice_i].gate;
    assign rd_sample_c = phase_q[rd_voice_i][PHASE_W-1 -: SAMPLE_ADDR_W];

endmodule

// File: rtl/wavetable_osc.sv
// Time-multiplexed wavetable oscillator: each sample_tick walks all voices
// (FETCH reads the ROM, ACC sums the voice term) and emits one mixed sample.
// Optional macro WAVETABLE_OSC_GAIN_EN scales each voice by its 8-bit gain.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   sample_tick                      starts a mix frame when idle
//   cfg_we/voice/inc/prog/gain/gate  per-voice configuration write
//   rom_re, rom_addr_prog/sample     sample ROM read request (FETCH only)
//   rom_data                         offset-binary sample, one cycle after rom_re
//   mix_out, mix_valid               signed mix and its one-cycle strobe
//   busy, overrun                    frame in progress; sticky tick-while-busy
module wavetable_osc import wavetable_pkg::*; #(
    parameter  int unsigned NUM_VOICES = 8,
    parameter  int unsigned PHASE_W    = 16,
    localparam int unsigned VOICE_W    = $clog2(NUM_VOICES),
    localparam int unsigned MIX_W      = SAMPLE_W + VOICE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_tick,
    input  logic                     cfg_we,
    input  logic [VOICE_W-1:0]       cfg_voice,
    input  logic [PHASE_W-1:0]       cfg_inc,
    input  logic [PROG_ADDR_W-1:0]   cfg_prog,
    input  logic [GAIN_W-1:0]        cfg_gain,
    input  logic                     cfg_gate,
    output logic                     rom_re,
    output logic [PROG_ADDR_W-1:0]   rom_addr_prog,
    output logic [SAMPLE_ADDR_W-1:0] rom_addr_sample,
    input  logic [SAMPLE_W-1:0]      rom_data,
    output logic signed [MIX_W-1:0]  mix_out,
    output logic                     mix_valid,
    output logic                     busy,
    output logic                     overrun
);

    state_e                    state_q, state_d;
    logic [VOICE_W-1:0]        voice_q, voice_d;
    logic signed [MIX_W-1:0]   acc_q, acc_d;
    logic signed [MIX_W-1:0]   mix_out_q, mix_out_d;
    logic                      mix_valid_q, mix_valid_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;
    logic                      rom_re_q, rom_re_d;
    logic [PROG_ADDR_W-1:0]    prog_q, prog_d;
    logic [SAMPLE_ADDR_W-1:0]  sample_q, sample_d;
    logic                      take_q;
    logic [PROG_ADDR_W-1:0]    rd_prog_c;
    logic [GAIN_W-1:0]         rd_gain_c;
    logic                      rd_gate_c;
    logic [SAMPLE_ADDR_W-1:0]  rd_sample_c;
    logic signed [SAMPLE_W-1:0] s_c, term_c;
    voice_cfg_t                cfg_c;

    assign cfg_c = '{prog: cfg_prog, gain: cfg_gain, gate: cfg_gate};

    // Phase advances on the FETCH->ACC edge, so a config write landing in
    // the same cycle only shapes the following frame.
    wavetable_voice_regs #(
        .NUM_VOICES (NUM_VOICES),
        .PHASE_W    (PHASE_W)
    ) u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we_i    (cfg_we),
        .cfg_voice_i (cfg_voice),
        .cfg_inc_i   (cfg_inc),
        .cfg_i       (cfg_c),
        .adv_i       ((state_q == FETCH) && rom_re_q),
        .adv_voice_i (voice_q),
        .rd_voice_i  (voice_d),
        .rd_prog_c   (rd_prog_c),
        .rd_gain_c   (rd_gain_c),
        .rd_gate_c   (rd_gate_c),
        .rd_sample_c (rd_sample_c)
    );

`ifdef WAVETABLE_OSC_GAIN_EN
    logic [GAIN_W-1:0]   gain_q;
    logic signed [15:0]  s16_c, g16_c, prod_c;

    // Gain is captured with the fetch so a mid-frame write cannot split a voice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        gain_q <= '0;
        else if (rom_re_d) gain_q <= rd_gain_c;
    end

    always_comb begin
        s_c    = to_signed(rom_data);
        s16_c  = 16'(s_c);
        g16_c  = 16'({1'b0, gain_q});
        prod_c = s16_c * g16_c;
        term_c = SAMPLE_W'(prod_c >>> 8);
    end
`else
    logic unused_gain;
    assign unused_gain = ^rd_gain_c;

    always_comb begin
        s_c    = to_signed(rom_data);
        term_c = s_c;
    end
`endif

    // Frame sequencing and registered-output next state.
    always_comb begin
        state_d     = state_q;
        voice_d     = voice_q;
        acc_d       = acc_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        overrun_d   = overrun_q | (sample_tick && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = FETCH;
                    voice_d = '0;
                    acc_d   = '0;
                end
            end
            FETCH: state_d = ACC;
            ACC: begin
                if (take_q) acc_d = acc_q + MIX_W'(term_c);
                if (voice_q != VOICE_W'(NUM_VOICES - 1)) begin
                    state_d = FETCH;
                    voice_d = voice_q + VOICE_W'(1);
                end else begin
                    state_d     = DONE;
                    mix_out_d   = acc_d;
                    mix_valid_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d != IDLE);
        rom_re_d = (state_d == FETCH) && rd_gate_c;
        prog_d   = rom_re_d ? rd_prog_c : '0;
        sample_d = rom_re_d ? rd_sample_c : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            voice_q     <= '0;
            acc_q       <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            rom_re_q    <= 1'b0;
            prog_q      <= '0;
            sample_q    <= '0;
            take_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            voice_q     <= voice_d;
            acc_q       <= acc_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            rom_re_q    <= rom_re_d;
            prog_q      <= prog_d;
            sample_q    <= sample_d;
            take_q      <= rom_re_q;
        end
    end

    assign rom_re          = rom_re_q;
    assign rom_addr_prog   = prog_q;
    assign rom_addr_sample = sample_q;
    assign mix_out         = mix_out_q;
    assign mix_valid       = mix_valid_q;
    assign busy            = busy_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_wavetable_osc.sv
// Scoreboard bench for wavetable_osc (8 voices, 16-bit phase).
module tb_wavetable_osc;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sample_tick = 1'b0;
    logic               cfg_we = 1'b0;
    logic [2:0]         cfg_voice = '0;
    logic [15:0]        cfg_inc = '0;
    logic [6:0]         cfg_prog = '0;
    logic [7:0]         cfg_gain = '0;
    logic               cfg_gate = 1'b0;
    logic               rom_re;
    logic [6:0]         rom_addr_prog;
    logic [5:0]         rom_addr_sample;
    logic [7:0]         rom_data = '0;
    logic signed [10:0] mix_out;
    logic               mix_valid;
    logic               busy;
    logic               overrun;

    logic [7:0] rom_val = 8'hC0;
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct { int cyc; int val; } mix_exp_t;
    typedef struct { int cyc; int prog; int smp; } rom_exp_t;
    mix_exp_t mixq[$];
    rom_exp_t romq[$];

    wavetable_osc dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sample_tick     (sample_tick),
        .cfg_we          (cfg_we),
        .cfg_voice       (cfg_voice),
        .cfg_inc         (cfg_inc),
        .cfg_prog        (cfg_prog),
        .cfg_gain        (cfg_gain),
        .cfg_gate        (cfg_gate),
        .rom_re          (rom_re),
        .rom_addr_prog   (rom_addr_prog),
        .rom_addr_sample (rom_addr_sample),
        .rom_data        (rom_data),
        .mix_out         (mix_out),
        .mix_valid       (mix_valid),
        .busy            (busy),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: requested data one cycle later, filler otherwise.
    always @(posedge clk) rom_data <= rom_re ? rom_val : 8'h5A;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT output event is matched against the scoreboards.
    initial begin
        mix_exp_t me;
        rom_exp_t re;
        forever begin
            @(negedge clk);
            if (mix_valid) begin
                if (mixq.size() == 0) begin
                    chk("unexpected_mix_valid_cycle", cyc, -1);
                end else begin
                    me = mixq.pop_front();
                    chk("mix_valid_cycle", cyc, me.cyc);
                    chk("mix_out", int'(mix_out), me.val);
                end
            end
            if (rom_re) begin
                if (romq.size() == 0) begin
                    chk("unexpected_rom_re_cycle", cyc, -1);
                end else begin
                    re = romq.pop_front();
                    chk("rom_re_cycle", cyc, re.cyc);
                    chk("rom_addr_prog", int'(rom_addr_prog), re.prog);
                    chk("rom_addr_sample", int'(rom_addr_sample), re.smp);
                end
            end
        end
    end

    task automatic cfg(input int v, input logic [15:0] inc, input int prog, input int gain, input bit gate);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_voice = 3'(v); cfg_inc = inc;
        cfg_prog = 7'(prog); cfg_gain = 8'(gain); cfg_gate = gate;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic tick(output int t0);
        @(posedge clk); #1;
        sample_tick = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic push_mix(input int c, input int v);
        mixq.push_back('{cyc: c, val: v});
    endtask

    task automatic push_rom(input int c, input int p, input int s);
        romq.push_back('{cyc: c, prog: p, smp: s});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || mixq.size() != 0 || romq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 200) begin
            n_err++;
            $display("FAIL %s: frame not drained, busy=%0d mix pending=%0d rom pending=%0d",
                     name, busy, mixq.size(), romq.size());
            mixq.delete();
            romq.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mix_out"}, int'(mix_out), 0);
        chk({tag, "_mix_valid"}, int'(mix_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_rom_re"}, int'(rom_re), 0);
        chk({tag, "_rom_addr"}, int'({rom_addr_prog, rom_addr_sample}), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int gain_a;

        // Reset state.
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        rst_n = 1'b1;

        // Single voice, sample index steps by one per frame.
        cfg(0, 16'h0400, 5, 0, 1'b1);
        rom_val = 8'hC0;
        tick(t0);
        push_rom(t0 + 1, 5, 0);
        push_mix(t0 + 17, 64);
        chk("busy_in_frame", int'(busy), 1);
        wait_idle("voice0_f1");
        chk("busy_after_frame", int'(busy), 0);
        tick(t0);
        push_rom(t0 + 1, 5, 1);
        push_mix(t0 + 17, 64);
        wait_idle("voice0_f2");
        repeat (3) @(posedge clk);
        #1 chk("mix_out_hold", int'(mix_out), 64);
        chk("no_overrun", int'(overrun), 0);

        // Phase wrap with a large increment.
        do_reset();
        cfg(0, 16'hFC00, 0, 0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            int exp_s [3] = '{0, 63, 62};
            tick(t0);
            push_rom(t0 + 1, 0, exp_s[f]);
            push_mix(t0 + 17, 64);
            wait_idle("wrap");
        end

        // Full scale, all voices.
        do_reset();
        for (int v = 0; v < 8; v++) cfg(v, 16'h0000, v, 0, 1'b1);
        rom_val = 8'hFF;
        tick(t0);
        for (int v = 0; v < 8; v++) push_rom(t0 + 1 + 2 * v, v, 0);
        push_mix(t0 + 17, 1016);
        wait_idle("full_pos");
        rom_val = 8'h00;
        tick(t0);
        for (int v = 0; v < 8; v++) push_rom(t0 + 1 + 2 * v, v, 0);
        push_mix(t0 + 17, -1024);
        wait_idle("full_neg");

        // Gain scaling (identity when the gain stage is not built).
`ifdef WAVETABLE_OSC_GAIN_EN
        gain_a = 32;
`else
        gain_a = 64;
`endif
        do_reset();
        cfg(0, 16'h0000, 3, 128, 1'b1);
        rom_val = 8'hC0;
        tick(t0);
        push_rom(t0 + 1, 3, 0);
        push_mix(t0 + 17, gain_a);
        wait_idle("gain_128");
        cfg(0, 16'h0000, 3, 255, 1'b1);
        rom_val = 8'h00;
        tick(t0);
        push_rom(t0 + 1, 3, 0);
        push_mix(t0 + 17, -128);
        wait_idle("gain_255");

        // Overrun: second tick at cycle 5 is dropped.
        tick(t0);
        push_rom(t0 + 1, 3, 0);
        push_mix(t0 + 17, -128);
        chk("overrun_before", int'(overrun), 0);
        repeat (4) @(posedge clk);
        #1 sample_tick = 1'b1;
        chk("second_tick_cycle", cyc - t0, 5);
        @(posedge clk); #1 sample_tick = 1'b0;
        chk("overrun_set", int'(overrun), 1);
        wait_idle("overrun_frame");
        repeat (5) @(posedge clk);
        #1 chk("overrun_held", int'(overrun), 1);
        chk("idle_after_overrun", int'(busy), 0);

        // Reset mid-frame aborts without mix_valid.
        do_reset();
        cfg(0, 16'h0400, 9, 0, 1'b1);
        rom_val = 8'hC0;
        tick(t0);
        push_rom(t0 + 1, 9, 0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        chk("reset_cycle", cyc - t0, 8);
        #1 chk_all_zero("midreset");
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_all_zero("released");
        cfg(0, 16'h0400, 9, 0, 1'b1);
        tick(t0);
        push_rom(t0 + 1, 9, 0);
        push_mix(t0 + 17, 64);
        wait_idle("after_reset");
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
